// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_timer
//  Description : Bus-mapped timer with NUM_CH channels. Each channel has a
//                prescaler, a one-shot option and an interrupt mask. The
//                channel interrupts are ORed into one IRQ, gated by IE.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_timer #(
    parameter int          ABUS_WIDTH = 32,
    parameter int          DBUS_WIDTH = 32,
    parameter int          NUM_CH     = 4,
    parameter int          CNT_WIDTH  = 32,
    parameter int          PRE_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hF0000020
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ABUS_WIDTH-1:0] aBus,
    inout  wire  [DBUS_WIDTH-1:0] dBus,
    input  logic                  wrtEn,
    input  logic                  IE,
    output logic                  IRQ
);

    localparam logic [ABUS_WIDTH-1:0] c_base = ABUS_WIDTH'(BASE_ADDR);
    localparam logic [ABUS_WIDTH-1:0] c_end  = c_base + ABUS_WIDTH'(16 * NUM_CH);

    logic [ABUS_WIDTH-3:0] w_woff;
    logic                  w_hit;
    logic [1:0]            w_reg;
    logic [NUM_CH-1:0]     w_sel;
    logic [NUM_CH-1:0]     w_irq_src;
    logic [DBUS_WIDTH-1:0] w_rd [NUM_CH];
    logic [DBUS_WIDTH-1:0] w_rdata;
    logic [DBUS_WIDTH-1:0] w_wdata;

    // Word offset from the base; the low two bits pick the register in a channel.
    assign w_woff  = aBus[ABUS_WIDTH-1:2] - c_base[ABUS_WIDTH-1:2];
    assign w_hit   = (aBus >= c_base) && (aBus < c_end) && (aBus[1:0] == 2'b00);
    assign w_reg   = w_woff[1:0];
    assign w_wdata = dBus;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CNT_WIDTH-1:0]  r_cnt;
        logic [CNT_WIDTH-1:0]  r_lim;
        logic [PRE_WIDTH-1:0]  r_pre;
        logic [PRE_WIDTH-1:0]  r_pc;
        logic                  r_ready;
        logic                  r_en;
        logic                  r_ovr;
        logic                  r_os;
        logic                  r_cie;
        logic                  w_tick;
        logic                  w_term;
        logic                  w_we;
        logic [DBUS_WIDTH-1:0] w_rd_reg;

        assign w_sel[n] = w_hit && (w_woff[ABUS_WIDTH-3:2] == (ABUS_WIDTH-4)'(n));
        assign w_we     = wrtEn && w_sel[n];
        assign w_tick   = r_en && (r_pc == r_pre);
        assign w_term   = w_tick && (r_lim != '0) && (r_cnt >= r_lim - CNT_WIDTH'(1));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt   <= '0;
                r_lim   <= '0;
                r_pre   <= '0;
                r_pc    <= '0;
                r_ready <= 1'b0;
                r_en    <= 1'b0;
                r_ovr   <= 1'b0;
                r_os    <= 1'b0;
                r_cie   <= 1'b0;
            end else begin
                if (w_we && (w_reg == 2'd0 || w_reg == 2'd3)) begin
                    r_pc <= '0;
                end else if (w_tick) begin
                    r_pc <= '0;
                end else if (r_en) begin
                    r_pc <= r_pc + PRE_WIDTH'(1);
                end

                if (w_we && w_reg == 2'd0) begin
                    r_cnt <= w_wdata[CNT_WIDTH-1:0];
                end else if (w_term) begin
                    r_cnt <= '0;
                end else if (w_tick) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end

                if (w_we && w_reg == 2'd1) begin
                    r_lim <= w_wdata[CNT_WIDTH-1:0];
                end
                if (w_we && w_reg == 2'd3) begin
                    r_pre <= w_wdata[PRE_WIDTH-1:0];
                end

                // A terminal event beats a same-cycle clear of the status bits.
                if (w_term) begin
                    r_ready <= 1'b1;
                    r_ovr   <= r_ovr | r_ready;
                end else if (w_we && w_reg == 2'd2) begin
                    if (!w_wdata[0]) r_ready <= 1'b0;
                    if (!w_wdata[2]) r_ovr   <= 1'b0;
                end

                if (w_we && w_reg == 2'd2) begin
                    r_en  <= w_wdata[1];
                    r_os  <= w_wdata[3];
                    r_cie <= w_wdata[4];
                end else if (w_term && r_os) begin
                    r_en <= 1'b0;
                end
            end
        end

        always_comb begin
            w_rd_reg = '0;
            case (w_reg)
                2'd0:    w_rd_reg = DBUS_WIDTH'(r_cnt);
                2'd1:    w_rd_reg = DBUS_WIDTH'(r_lim);
                2'd2:    w_rd_reg = DBUS_WIDTH'({r_cie, r_os, r_ovr, r_en, r_ready});
                default: w_rd_reg = DBUS_WIDTH'(r_pre);
            endcase
        end

        assign w_rd[n]      = w_sel[n] ? w_rd_reg : '0;
        assign w_irq_src[n] = r_ready & r_cie;
    end

    always_comb begin
        w_rdata = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_rdata = w_rdata | w_rd[n];
        end
    end

    assign dBus = (w_hit && !wrtEn) ? w_rdata : {DBUS_WIDTH{1'bz}};
    assign IRQ  = IE & (|w_irq_src);

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_timer
//  Description : Directed vector table, hand sequences and random traffic
//                for multi_timer, checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_timer;

    localparam int          NUM_CH = 4;
    localparam logic [31:0] BASE   = 32'hF0000020;
    localparam logic [31:0] IDLE   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aBus;
    logic        wrtEn;
    logic        IE;
    wire         IRQ;
    tri1  [31:0] dBus;
    logic        r_drv;
    logic [31:0] r_wdata;

    assign dBus = r_drv ? r_wdata : 32'hzzzz_zzzz;

    multi_timer #(
        .ABUS_WIDTH(32), .DBUS_WIDTH(32), .NUM_CH(NUM_CH),
        .CNT_WIDTH(32), .PRE_WIDTH(8), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .aBus(aBus), .dBus(dBus),
        .wrtEn(wrtEn), .IE(IE), .IRQ(IRQ)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit r_mchk   = 1'b0;

    // Behavioural model state
    logic [31:0] m_cnt [NUM_CH];
    logic [31:0] m_lim [NUM_CH];
    logic [7:0]  m_pre [NUM_CH];
    int          m_pc  [NUM_CH];
    bit          m_rdy [NUM_CH];
    bit          m_en  [NUM_CH];
    bit          m_ovr [NUM_CH];
    bit          m_os  [NUM_CH];
    bit          m_cie [NUM_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_z(input string name, input logic [31:0] act);
        n_checks++;
        if (!(act === 32'hFFFF_FFFF || act === 32'hzzzz_zzzz)) begin
            n_fail++;
            $display("FAIL %s: got %h expected high-Z", name, act);
        end
    endtask

    function automatic void m_reset();
        for (int n = 0; n < NUM_CH; n++) begin
            m_cnt[n] = 0; m_lim[n] = 0; m_pre[n] = 0; m_pc[n] = 0;
            m_rdy[n] = 0; m_en[n] = 0; m_ovr[n] = 0; m_os[n] = 0; m_cie[n] = 0;
        end
    endfunction

    function automatic void m_decode(input logic [31:0] a, output bit hit,
                                     output int ch, output int rg);
        longint off;
        off = longint'(a) - longint'(BASE);
        hit = (off >= 0) && (off < 16 * NUM_CH) && (a % 4 == 0);
        ch  = hit ? int'(off / 16) : -1;
        rg  = hit ? int'((off % 16) / 4) : -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit hit);
        int ch, rg;
        m_decode(a, hit, ch, rg);
        m_read = 32'h0;
        if (hit) begin
            case (rg)
                0:       m_read = m_cnt[ch];
                1:       m_read = m_lim[ch];
                2:       m_read = {27'b0, m_cie[ch], m_os[ch], m_ovr[ch], m_en[ch], m_rdy[ch]};
                default: m_read = {24'b0, m_pre[ch]};
            endcase
        end
    endfunction

    function automatic bit m_irq(input bit ie);
        bit any = 1'b0;
        for (int n = 0; n < NUM_CH; n++) any |= m_rdy[n] & m_cie[n];
        return ie & any;
    endfunction

    function automatic void m_step(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int ch, rg;
        bit hit;
        m_decode(a, hit, ch, rg);
        for (int n = 0; n < NUM_CH; n++) begin
            bit     w, tick, term, old_rdy, old_ovr, old_os;
            longint nxt;
            logic [31:0] nxt32;
            w       = wr && hit && (ch == n);
            tick    = m_en[n] && (m_pc[n] == int'(m_pre[n]));
            nxt     = longint'(m_cnt[n]) + 1;
            nxt32   = m_cnt[n] + 32'd1;
            term    = tick && (m_lim[n] != 0) && (nxt >= longint'(m_lim[n]));
            old_rdy = m_rdy[n];
            old_ovr = m_ovr[n];
            old_os  = m_os[n];

            if (w && (rg == 0 || rg == 3)) m_pc[n] = 0;
            else if (tick)                 m_pc[n] = 0;
            else if (m_en[n])              m_pc[n] = m_pc[n] + 1;

            if (w && rg == 0)  m_cnt[n] = d;
            else if (term)     m_cnt[n] = 0;
            else if (tick)     m_cnt[n] = nxt32;

            if (w && rg == 1) m_lim[n] = d;
            if (w && rg == 3) m_pre[n] = d[7:0];

            if (w && rg == 2) begin
                if (!d[0]) m_rdy[n] = 0;
                if (!d[2]) m_ovr[n] = 0;
                m_os[n]  = d[3];
                m_cie[n] = d[4];
                m_en[n]  = d[1];
            end else if (term && old_os) begin
                m_en[n] = 0;
            end
            if (term) begin
                m_rdy[n] = 1;
                m_ovr[n] = old_ovr | old_rdy;
            end
        end
    endfunction

    // One bus cycle: drive, sample before the edge, then clock DUT and model.
    task automatic do_cycle(input bit rst, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input bit ie,
                            output logic [31:0] rd, output logic irq);
        bit          hit;
        logic [31:0] exp;
        reset = rst; wrtEn = wr; aBus = addr; r_drv = wr; r_wdata = data; IE = ie;
        #2;
        rd  = dBus;
        irq = IRQ;
        if (r_mchk) begin
            exp = m_read(addr, hit);
            if (!wr) begin
                if (hit) chk($sformatf("model_rd@%h", addr), rd, exp);
                else     chk_z($sformatf("model_z@%h", addr), rd);
            end
            chk("model_irq", {31'b0, irq}, {31'b0, m_irq(ie)});
        end
        @(posedge clk);
        if (rst) m_reset();
        else     m_step(wr, addr, data);
        #1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          ie;
        logic [31:0] exp;
        bit          exp_irq;
        bit          z;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_r(input logic [31:0] a, input logic [31:0] e,
                                  input bit ie, input bit eirq);
        tbl.push_back('{1'b0, a, 32'h0, ie, e, eirq, 1'b0});
    endfunction
    function automatic void add_z(input logic [31:0] a);
        tbl.push_back('{1'b0, a, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1});
    endfunction
    function automatic void add_w(input logic [31:0] a, input logic [31:0] d,
                                  input bit ie, input bit eirq);
        tbl.push_back('{1'b1, a, d, ie, 32'h0, eirq, 1'b0});
    endfunction

    logic [31:0] rd;
    logic        irq;

    initial begin
        reset = 1'b1; wrtEn = 1'b0; aBus = IDLE; IE = 1'b0; r_drv = 1'b0; r_wdata = 32'h0;
        m_reset();
        @(posedge clk); #1;
        do_cycle(1'b1, 1'b0, IDLE, 32'h0, 1'b0, rd, irq);
        do_cycle(1'b1, 1'b0, IDLE, 32'h0, 1'b0, rd, irq);
        r_mchk = 1'b1;

        // Reset state and decode boundaries
        for (int i = 0; i < 16 * NUM_CH; i += 4) add_r(BASE + 32'(i), 32'h0, 1'b1, 1'b0);
        add_z(BASE + 32'(16 * NUM_CH));
        add_z(BASE + 32'h2);
        add_z(BASE - 32'h4);
        // Ch0 periodic, LIM=5, EN+CIE
        add_w(32'hF000_0024, 32'd5, 1, 0);
        add_w(32'hF000_002C, 32'd0, 1, 0);
        add_w(32'hF000_0028, 32'h12, 1, 0);
        for (int i = 0; i < 5; i++) add_r(32'hF000_0020, 32'(i), 1, 0);
        for (int i = 0; i < 5; i++) add_r(32'hF000_0020, 32'(i), 1, 1);
        add_r(32'hF000_0028, 32'h17, 1, 1);
        add_w(32'hF000_0028, 32'h12, 1, 1);
        add_r(32'hF000_0028, 32'h12, 1, 0);
        add_w(32'hF000_0028, 32'h00, 1, 0);
        add_r(32'hF000_0020, 32'd4, 1, 0);
        // Ch1 one-shot with prescaler 3, LIM=2
        add_w(32'hF000_003C, 32'd3, 1, 0);
        add_w(32'hF000_0034, 32'd2, 1, 0);
        add_w(32'hF000_0038, 32'h0A, 1, 0);
        for (int i = 0; i < 8; i++) add_r(32'hF000_0030, (i < 4) ? 32'd0 : 32'd1, 1, 0);
        add_r(32'hF000_0030, 32'd0, 1, 0);
        add_r(32'hF000_0038, 32'h09, 1, 0);
        for (int i = 0; i < 3; i++) add_r(32'hF000_0030, 32'd0, 1, 0);
        // Ch2 IE / CIE gating and clear-versus-event collision
        add_w(32'hF000_0044, 32'd1, 0, 0);
        add_w(32'hF000_0048, 32'h12, 0, 0);
        add_r(32'hF000_0040, 32'd0, 0, 0);
        add_r(32'hF000_0048, 32'h13, 0, 0);
        add_r(32'hF000_0040, 32'd0, 1, 1);
        add_w(32'hF000_0048, 32'h03, 1, 1);
        add_r(32'hF000_0040, 32'd0, 1, 0);
        add_r(32'hF000_0048, 32'h07, 0, 0);
        add_w(32'hF000_0048, 32'h00, 0, 0);
        add_r(32'hF000_0048, 32'h05, 0, 0);
        add_w(32'hF000_0048, 32'h00, 0, 0);
        add_r(32'hF000_0048, 32'h00, 0, 0);
        // Ch0 LIM written below CNT, then free-running wrap
        add_w(32'hF000_0020, 32'd10, 0, 0);
        add_w(32'hF000_0024, 32'd4, 0, 0);
        add_w(32'hF000_0028, 32'h02, 0, 0);
        add_r(32'hF000_0020, 32'd10, 0, 0);
        add_r(32'hF000_0020, 32'd0, 0, 0);
        add_r(32'hF000_0028, 32'h03, 0, 0);
        add_w(32'hF000_0024, 32'd0, 0, 0);
        add_w(32'hF000_0028, 32'h02, 0, 0);
        add_w(32'hF000_0020, 32'hFFFF_FFFF, 0, 0);
        add_r(32'hF000_0020, 32'hFFFF_FFFF, 0, 0);
        add_r(32'hF000_0020, 32'd0, 0, 0);
        add_r(32'hF000_0028, 32'h02, 0, 0);
        // Ch3 one-shot event colliding with an EN write
        add_w(32'hF000_0054, 32'd1, 0, 0);
        add_w(32'hF000_0058, 32'h0A, 0, 0);
        add_w(32'hF000_0058, 32'h0A, 0, 0);
        add_r(32'hF000_0058, 32'h0B, 0, 0);
        add_r(32'hF000_0058, 32'h0D, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].ie, rd, irq);
            if (!tbl[i].wr) begin
                if (tbl[i].z) chk_z($sformatf("vec%0d_z", i), rd);
                else          chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp);
            end
            chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
        end

        // Reset in the middle of activity
        do_cycle(1'b0, 1'b1, 32'hF000_0048, 32'h12, 1'b1, rd, irq);
        do_cycle(1'b0, 1'b0, 32'hF000_0020, 32'h0, 1'b1, rd, irq);
        do_cycle(1'b0, 1'b0, 32'hF000_0020, 32'h0, 1'b1, rd, irq);
        chk("pre_reset_irq", {31'b0, irq}, 32'h1);
        do_cycle(1'b1, 1'b0, 32'hF000_0020, 32'h0, 1'b1, rd, irq);
        do_cycle(1'b0, 1'b0, 32'hF000_0020, 32'h0, 1'b1, rd, irq);
        chk("post_reset_cnt0", rd, 32'h0);
        chk("post_reset_irq", {31'b0, irq}, 32'h0);
        do_cycle(1'b0, 1'b0, 32'hF000_0048, 32'h0, 1'b1, rd, irq);
        chk("post_reset_ctl2", rd, 32'h0);
        do_cycle(1'b0, 1'b0, 32'hF000_0044, 32'h0, 1'b1, rd, irq);
        chk("post_reset_lim2", rd, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int          r, ch, rg;
            logic [31:0] a, d;
            bit          ie;
            r  = int'($urandom_range(0, 999));
            ch = int'($urandom_range(0, NUM_CH - 1));
            rg = int'($urandom_range(0, 3));
            ie = ($urandom_range(0, 3) != 0);
            a  = BASE + 32'(16 * ch + 4 * rg);
            if ($urandom_range(0, 19) == 0)
                a = ($urandom_range(0, 1) != 0) ? BASE + 32'(16 * NUM_CH + 4 * rg)
                                                : a + 32'($urandom_range(1, 3));
            case (rg)
                0:       d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 8));
                1:       d = 32'($urandom_range(0, 6));
                2:       d = 32'($urandom_range(0, 31));
                default: d = 32'($urandom_range(0, 3));
            endcase
            if (r < 3)        do_cycle(1'b1, 1'b0, a, d, ie, rd, irq);
            else if (r < 300) do_cycle(1'b0, 1'b1, a, d, ie, rd, irq);
            else              do_cycle(1'b0, 1'b0, a, d, ie, rd, irq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
